// File: rtl/fpu_sched_if.sv
// fpu_sched_if
// Bundles the request and response signals of the shared FPU scheduler.
//   master : requester side. It drives req_valid/req_op/req_a/req_b and rsp_ready,
//            and receives req_ready and the response fields.
//   slave  : scheduler side. It drives req_ready and
//            rsp_valid/rsp_id/rsp_data/rsp_err.
// Packing: requester i owns req_op[3i+2:3i], req_a[W*i+W-1:W*i] and req_b (same layout).
interface fpu_sched_if #(
    parameter int NX   = 8,
    parameter int NM   = 23,
    parameter int NREQ = 4
);
    localparam int W  = 1 + NX + NM;
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/fpu_sched.sv
// fpu_sched
// Lets NREQ requesters share one floating-point unit. Only one job is in flight at a time.
// The scheduler grants one requester, captures its op and operands, and waits a fixed
// number of cycles set by the op class. It then registers the result and holds it until
// the response handshake completes.
// Ports:
//   clk  : single clock. All state changes on the rising edge.
//   rst  : synchronous, active-high reset.
//   bus  : fpu_sched_if.slave (request vectors, req_ready, and the response channel)
//   busy : high whenever the scheduler is not IDLE.
// Op codes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 TOINT, 5 FROMINT, 6/7 illegal (rsp_err=1, data 0).
// FPU arithmetic:
//   - Normal numbers only. A zero exponent field is treated as zero.
//   - Results are truncated, not rounded.
//   - Overflow saturates to infinity and underflow flushes to zero.
// Build option FPU_SCHED_FIXED_PRIO_EN:
//   - defined   : fixed-priority grant (lowest index wins).
//   - undefined : round-robin grant starting at a rotating pointer.
module fpu_sched #(
    parameter int NX      = 8,
    parameter int NM      = 23,
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 12,
    parameter int CVT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    fpu_sched_if.slave  bus,
    output logic        busy
);
    localparam int W      = 1 + NX + NM;
    localparam int IW     = $clog2(NREQ);
    localparam int MW     = NM + 1;                 // significand incl. hidden bit
    localparam int BIAS   = (1 << (NX - 1)) - 1;
    localparam int EMAX   = (1 << NX) - 1;
    localparam int MAXLAT = (ADD_LAT > MUL_LAT)
                          ? ((ADD_LAT > DIV_LAT) ? ((ADD_LAT > CVT_LAT) ? ADD_LAT : CVT_LAT)
                                                 : ((DIV_LAT > CVT_LAT) ? DIV_LAT : CVT_LAT))
                          : ((MUL_LAT > DIV_LAT) ? ((MUL_LAT > CVT_LAT) ? MUL_LAT : CVT_LAT)
                                                 : ((DIV_LAT > CVT_LAT) ? DIV_LAT : CVT_LAT));
    localparam int CW     = $clog2(MAXLAT + 1);

    // Signed exponent with enough headroom for sums, differences and under/overflow.
    typedef logic signed [NX+2:0] exp_t;
    localparam exp_t E_ZERO = exp_t'(0);
    localparam exp_t E_ONE  = exp_t'(1);
    localparam exp_t E_BIAS = exp_t'(BIAS);
    localparam exp_t E_MAX  = exp_t'(EMAX);
    localparam exp_t E_NM   = exp_t'(NM);
    localparam exp_t E_INTW = exp_t'(W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_r;
    logic [W-1:0]    a_r, b_r;
    logic            grant_any;
    logic [IW-1:0]   grant_idx;
    logic            take;
    logic [W-1:0]    res_data;
    logic            res_err;
`ifndef FPU_SCHED_FIXED_PRIO_EN
    logic [IW-1:0]   ptr;
    int              rr_idx;
`endif

    // ------------------------------------------------------------------
    // FPU primitives
    // ------------------------------------------------------------------
    function automatic exp_t exp_of(input logic [W-1:0] v);
        return exp_t'({3'b000, v[W-2 -: NX]});
    endfunction

    // Packs a result. Underflow flushes to signed zero and overflow saturates to infinity.
    function automatic logic [W-1:0] pack(input logic s, input exp_t e, input logic [NM-1:0] f);
        if (e <= E_ZERO)
            return {s, {(W-1){1'b0}}};
        else if (e >= E_MAX)
            return {s, {NX{1'b1}}, {NM{1'b0}}};
        else
            return {s, e[NX-1:0], f};
    endfunction

    function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0]  x, y;
        logic [MW+2:0] mx, my;          // three guard bits below the LSB
        logic [MW+3:0] sum;
        exp_t          e;
        // Comparing the bits below the sign orders normal numbers by magnitude.
        if (a[W-2:0] >= b[W-2:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        if (y[W-2 -: NX] == '0)
            return x;
        e   = exp_of(x);
        mx  = {1'b1, x[NM-1:0], 3'b000};
        my  = {1'b1, y[NM-1:0], 3'b000} >> (exp_of(x) - exp_of(y));
        if (x[W-1] == y[W-1]) begin
            sum = {1'b0, mx} + {1'b0, my};
            if (sum[MW+3]) begin
                sum = sum >> 1;
                e   = e + E_ONE;
            end
        end else begin
            sum = {1'b0, mx} - {1'b0, my};
            if (sum == '0)
                return '0;
            for (int i = 0; i < MW + 3; i++) begin
                if (!sum[MW+2]) begin
                    sum = sum << 1;
                    e   = e - E_ONE;
                end
            end
        end
        return pack(x[W-1], e, sum[MW+1:3]);
    endfunction

    function automatic logic [W-1:0] fp_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        return fp_add(a, {~b[W-1], b[W-2:0]});
    endfunction

    function automatic logic [W-1:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*MW-1:0] p;
        logic            s;
        exp_t            e;
        s = a[W-1] ^ b[W-1];
        if (a[W-2 -: NX] == '0 || b[W-2 -: NX] == '0)
            return {s, {(W-1){1'b0}}};
        p = {{MW{1'b0}}, 1'b1, a[NM-1:0]} * {{MW{1'b0}}, 1'b1, b[NM-1:0]};
        e = exp_of(a) + exp_of(b) - E_BIAS;
        // Product of two [1,2) significands lies in [1,4).
        if (p[2*MW-1])
            return pack(s, e + E_ONE, p[2*MW-2 -: NM]);
        else
            return pack(s, e, p[2*MW-3 -: NM]);
    endfunction

    function automatic logic [W-1:0] fp_div(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*MW-1:0] num, den;
        logic [MW:0]     q;
        logic            s;
        exp_t            e;
        s = a[W-1] ^ b[W-1];
        if (b[W-2 -: NX] == '0) begin
            if (a[W-2 -: NX] == '0)
                return {1'b0, {NX{1'b1}}, 1'b1, {(NM-1){1'b0}}};   // 0/0: quiet NaN
            return {s, {NX{1'b1}}, {NM{1'b0}}};                     // x/0: infinity
        end
        if (a[W-2 -: NX] == '0)
            return {s, {(W-1){1'b0}}};
        num = {1'b1, a[NM-1:0], {MW{1'b0}}};
        den = {{MW{1'b0}}, 1'b1, b[NM-1:0]};
        q   = (MW+1)'(num / den);
        e   = exp_of(a) - exp_of(b) + E_BIAS;
        // Quotient of two [1,2) significands lies in (0.5,2).
        if (q[MW])
            return pack(s, e, q[MW-1 -: NM]);
        else
            return pack(s, e - E_ONE, q[MW-2 -: NM]);
    endfunction

    // Converts to a W-bit signed integer, truncating toward zero. Out-of-range values saturate.
    function automatic logic [W-1:0] fp_to_int(input logic [W-1:0] a);
        logic [W-1:0] mag;
        exp_t         e;
        e = exp_of(a) - E_BIAS;
        if (a[W-2 -: NX] == '0 || e < E_ZERO)
            return '0;
        if (e >= E_INTW)
            return a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        mag = {{(W-MW){1'b0}}, 1'b1, a[NM-1:0]};
        if (e >= E_NM)
            mag = mag << (e - E_NM);
        else
            mag = mag >> (E_NM - e);
        return a[W-1] ? -mag : mag;
    endfunction

    // Converts a W-bit signed integer to float, truncating the bits that do not fit.
    function automatic logic [W-1:0] fp_from_int(input logic [W-1:0] a);
        logic [W-1:0]    mag;
        logic [W+NM-1:0] wide;
        logic            s;
        int              p;
        if (a == '0)
            return '0;
        s   = a[W-1];
        mag = s ? -a : a;
        p   = 0;
        for (int i = 0; i < W; i++)
            if (mag[i]) p = i;
        wide = {mag, {NM{1'b0}}} >> p;      // leading one lands on bit NM
        return pack(s, exp_t'(p) + E_BIAS, wide[NM-1:0]);
    endfunction

    function automatic logic [CW-1:0] lat_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return CW'(ADD_LAT - 1);
            3'd2:       return CW'(MUL_LAT - 1);
            3'd3:       return CW'(DIV_LAT - 1);
            default:    return CW'(CVT_LAT - 1);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
`ifdef FPU_SCHED_FIXED_PRIO_EN
        // Scanning from the top means the lowest valid index is the final assignment.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = IW'(i);
            end
        end
`else
        rr_idx = 0;
        // Scanning the offsets from the far end means the first valid index at or after
        // ptr is the final assignment.
        for (int k = NREQ - 1; k >= 0; k--) begin
            rr_idx = int'(ptr) + k;
            if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
            if (bus.req_valid[rr_idx]) begin
                grant_any = 1'b1;
                grant_idx = IW'(rr_idx);
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        take          = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any && !rst) begin
                    bus.req_ready[grant_idx] = 1'b1;
                    take                     = 1'b1;
                    state_nxt                = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rsp_valid = (state == DONE);
    assign busy          = (state != IDLE);

    // ------------------------------------------------------------------
    // Shared FPU: evaluates the captured job every cycle.
    // The result is sampled only when the countdown expires.
    // ------------------------------------------------------------------
    always_comb begin
        res_data = '0;
        res_err  = 1'b0;
        case (op_r)
            3'd0:    res_data = fp_add(a_r, b_r);
            3'd1:    res_data = fp_sub(a_r, b_r);
            3'd2:    res_data = fp_mul(a_r, b_r);
            3'd3:    res_data = fp_div(a_r, b_r);
            3'd4:    res_data = fp_to_int(a_r);
            3'd5:    res_data = fp_from_int(a_r);
            default: res_err  = 1'b1;
        endcase
    end

    // Operands carry no reset. They are always written at a grant before they are used.
    always_ff @(posedge clk) begin
        if (take) begin
            op_r <= bus.req_op[3*int'(grant_idx) +: 3];
            a_r  <= bus.req_a[W*int'(grant_idx) +: W];
            b_r  <= bus.req_b[W*int'(grant_idx) +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            bus.rsp_id   <= '0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
`ifndef FPU_SCHED_FIXED_PRIO_EN
            ptr          <= '0;
`endif
        end else begin
            if (take) begin
                cnt        <= lat_of(bus.req_op[3*int'(grant_idx) +: 3]);
                bus.rsp_id <= grant_idx;
`ifndef FPU_SCHED_FIXED_PRIO_EN
                ptr        <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
`endif
            end
            if (state == BUSY) begin
                if (cnt == '0) begin
                    bus.rsp_data <= res_data;
                    bus.rsp_err  <= res_err;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end
endmodule

// File: doc/fpu_sched.md
FPU_SCHED -- requirements
Module: fpu_sched

Interface
REQ-001 SHALL have parameter NX, default 8, exponent width of the operand format.
REQ-002 SHALL have parameter NM, default 23, mantissa width of the operand format; word width W = 1+NX+NM.
REQ-003 SHALL have parameter NREQ, default 4, number of requesters (2..16); IW = $clog2(NREQ).
REQ-004 SHALL have parameters ADD_LAT=2, MUL_LAT=3, DIV_LAT=12, CVT_LAT=1, each the BUSY cycles for that op class (each >=1).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port req_valid  input  NREQ  per-requester request valid.
REQ-008 SHALL have port req_ready  output  NREQ  per-requester accept; at most one bit set.
REQ-009 SHALL have port req_op  input  3*NREQ  op code of requester i at bits [3i+2:3i].
REQ-010 SHALL have port req_a  input  W*NREQ  operand A of requester i at bits [W*i+W-1:W*i].
REQ-011 SHALL have port req_b  input  W*NREQ  operand B, same packing.
REQ-012 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_id output IW (granted requester), rsp_data output W, rsp_err output 1 (illegal op).
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Op codes SHALL be 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 TOINT, 5 FROMINT; 6,7 illegal.
REQ-015 Results SHALL be bit-identical to the shared fpu functions add, sub, mul, div, to_integer, from_integer at (NX,NM); one fpu instance shared by all requesters.
REQ-016 Latency class: ADD/SUB ADD_LAT, MUL MUL_LAT, DIV DIV_LAT, TOINT/FROMINT/illegal CVT_LAT.
REQ-017 FSM states IDLE, BUSY, DONE.
REQ-018 IDLE: if any req_valid, req_ready[g] SHALL be driven high combinationally in that cycle for the granted g only; at the edge op/a/b/g are captured, cnt=LAT-1, next state BUSY.
REQ-019 req_ready SHALL be all-zero in BUSY and DONE; no request is accepted while a job is outstanding.
REQ-020 Grant SHALL be round-robin: first valid index at or after ptr, wrapping NREQ-1 -> 0; on grant ptr = (g+1) mod NREQ.
REQ-021 BUSY: cnt decrements each cycle; in the cycle cnt==0 the result is registered into rsp_data/rsp_err and next state DONE.
REQ-022 Handshake at cycle T SHALL give rsp_valid first high in cycle T+1+LAT.
REQ-023 DONE: rsp_valid=1; rsp_id/rsp_data/rsp_err stable until rsp_valid&&rsp_ready, then next state IDLE (a new grant is possible in the following cycle, not the same one).
REQ-024 Illegal op: rsp_data=0, rsp_err=1; legal ops rsp_err=0; DIV by zero returns fpu.div output unmodified, rsp_err=0.
REQ-025 Requester inputs not granted SHALL be ignored; a requester dropping req_valid before grant loses nothing.

Reset
REQ-026 rst high at an edge SHALL set state IDLE, ptr 0, cnt 0, rsp_valid 0, rsp_err 0, rsp_id 0, rsp_data 0, busy 0, from any state.
REQ-027 Reset mid-BUSY or in DONE SHALL discard the job; no response is produced for it.
REQ-028 While rst is high, req_ready SHALL be all-zero.

Configuration
REQ-029 Macro FPU_SCHED_FIXED_PRIO_EN defined: grant SHALL be fixed priority, lowest valid index wins, ptr unused.
REQ-030 Macro undefined: round-robin per REQ-020.

Verification (NX=8, NM=23, NREQ=4, default latencies)
REQ-031 req0 ADD 0x3F800000+0x40000000 accepted cycle 0, rsp_ready=1 -> rsp_valid cycle 3, rsp_id 0, rsp_data 0x40400000, rsp_err 0.
REQ-032 All four req_valid held, MUL 0x40000000*0x40400000 -> grants 0,1,2,3,0 in order, each rsp_data 0x40C00000.
REQ-033 req2 DIV 0x40C00000/0x40000000, rsp_ready low 5 cycles after rsp_valid -> response held stable, busy 1, req_ready 0000; released -> 0x40400000, id 2.
REQ-034 req1 op 7 -> rsp_err 1, rsp_data 0 at cycle T+2; req3 TOINT 0x40C00000 -> rsp_data 6.
REQ-035 rst pulsed in cycle 5 of a DIV -> next cycle busy 0, no rsp_valid for it, next grant goes to lowest valid index.
REQ-036 FPU_SCHED_FIXED_PRIO_EN defined, req1 and req3 held valid -> every grant to 1.
